data_mem_interface: RTL and testbench

Sequential bridge between `load_store_controller` and the data-memory bus. It captures one load or store request per `start` pulse: effective address, write flag, size enables and store data. It then drives a valid/ready request with byte strobes and lane-replicated write data, waits for the response, and returns the addressed bytes right-justified on `mrdin` for the controller's sign/zero-extension. It also stalls the core via `busy` and flags misaligned or timed-out accesses.

---
 rtl/dmi_pkg.sv | 30 +++
 rtl/byte_lane_aligner.sv | 54 +++++
 rtl/data_mem_interface.sv | 212 +++++++++++++++++++++
 tb/tb_data_mem_interface.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmi_pkg.sv
// Shared definitions for the data-memory interface.
//   state_t  : controller states IDLE / REQ / RESP
//   size_t   : access size codes SZ_B / SZ_H / SZ_W
//   DMI_DEFAULT_TIMEOUT : default abort limit, in cycles spent in REQ+RESP
//   size_decode()       : size-enable priority, word over half over byte
package dmi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  localparam int unsigned DMI_DEFAULT_TIMEOUT = 255;

  // Callers check that at least one enable is set. With only b_e set,
  // or with none set, the result falls through to byte.
  function automatic size_t size_decode(input logic w_e, input logic h_e);
    if (w_e)      return SZ_W;
    else if (h_e) return SZ_H;
    else          return SZ_B;
  endfunction

endpackage

// File: rtl/byte_lane_aligner.sv
// Purely combinational lane steering between the core and a 32-bit bus.
// Ports:
//   size     in  access size (SZ_B / SZ_H / SZ_W)
//   offset   in  byte offset within the word; the caller has already cleared
//                the bits that the access size does not use
//   b_in, h_in, w_in  in  store data for byte / half / word
//   rdata    in  raw bus read word
//   wstrb    out byte strobes for a store
//   wdata    out store data replicated across every lane the size can occupy
//   rdata_rj out addressed bytes right-justified, upper bits zero
module byte_lane_aligner
  import dmi_pkg::*;
(
  input  size_t       size,
  input  logic [1:0]  offset,
  input  logic [7:0]  b_in,
  input  logic [15:0] h_in,
  input  logic [31:0] w_in,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] rdata_rj
);

  logic [31:0] rd_shift;

  // NOTE: every output of a combinational block gets a default first, so
  // that no path through the case can leave an output unassigned (which
  // would infer a latch).
  always_comb begin
    wstrb    = 4'b1111;
    wdata    = w_in;
    rdata_rj = rdata;
    rd_shift = rdata >> {offset, 3'b000};
    case (size)
      SZ_B: begin
        wstrb    = 4'b0001 << offset;
        wdata    = {4{b_in}};
        rdata_rj = {24'b0, rd_shift[7:0]};
      end
      SZ_H: begin
        wstrb    = offset[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{h_in}};
        rdata_rj = {16'b0, offset[1] ? rdata[31:16] : rdata[15:0]};
      end
      default: begin
        wstrb    = 4'b1111;
        wdata    = w_in;
        rdata_rj = rdata;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_interface.sv
// Bridge between load_store_controller and a valid/ready data-memory bus.
// It captures one load or store per start pulse, issues one bus request,
// waits for the response and returns the read data right-justified.
//
// Parameter: TIMEOUT (1..65535) is the maximum number of cycles spent in
//   REQ+RESP before the access is aborted with bus_err.
// Ports:
//   clk, rst_n                    clock; synchronous active-low reset
//   start, addr, wr               request pulse, byte address, 1 = store
//   b_e, h_e, w_e                 size enables (word > half > byte)
//   w_in, h_in, b_in              store data
//   bus_valid/bus_ready           request handshake
//   bus_addr, bus_we, bus_wstrb, bus_wdata   request fields
//   bus_rvalid, bus_rdata         response (read data or write ack)
//   mrdin                         right-justified load data
//   busy, done                    core stall; one-cycle completion pulse
//   misalign_err, bus_err         status, valid while done = 1
// Build option: DMI_MISALIGN_TRAP_EN. When defined, a misaligned half or
//   word access completes at once with misalign_err and makes no bus
//   request. When undefined, the offending low address bits are cleared and
//   the access proceeds.
module data_mem_interface
  import dmi_pkg::*;
#(
  parameter int unsigned TIMEOUT = DMI_DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic        wr,
  input  logic        b_e,
  input  logic        h_e,
  input  logic        w_e,
  input  logic [31:0] w_in,
  input  logic [15:0] h_in,
  input  logic [7:0]  b_in,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic [31:0] mrdin,
  output logic        busy,
  output logic        done,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int unsigned   CW      = $clog2(TIMEOUT + 1);
  // The abort fires on the edge that ends the TIMEOUT-th cycle in REQ+RESP,
  // when the counter still shows TIMEOUT-1.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  size_t         size_in, size_q, al_size;
  logic [1:0]    off_in, off_q, al_off;
  logic          req_en, trap_in;
  logic          start_req, resp_done, abort, timeout_hit;
  logic [3:0]    al_wstrb;
  logic [31:0]   al_wdata, al_rdata;

  // Request decode. The offset is masked to the access size, so a
  // misaligned half or word is handled as its aligned counterpart.
  always_comb begin
    req_en  = b_e | h_e | w_e;
    size_in = size_decode(w_e, h_e);
    case (size_in)
      SZ_W:    off_in = 2'b00;
      SZ_H:    off_in = {addr[1], 1'b0};
      default: off_in = addr[1:0];
    endcase
  end

`ifdef DMI_MISALIGN_TRAP_EN
  assign trap_in = ((size_in == SZ_H) && addr[0]) ||
                   ((size_in == SZ_W) && (addr[1:0] != 2'b00));
`else
  assign trap_in = 1'b0;
`endif

  // In IDLE the aligner encodes the incoming store. In RESP it extracts the
  // load from the size and offset captured when the request was accepted.
  assign al_size = (state == IDLE) ? size_in : size_q;
  assign al_off  = (state == IDLE) ? off_in  : off_q;

  byte_lane_aligner u_aligner (
    .size     (al_size),
    .offset   (al_off),
    .b_in     (b_in),
    .h_in     (h_in),
    .w_in     (w_in),
    .rdata    (bus_rdata),
    .wstrb    (al_wstrb),
    .wdata    (al_wdata),
    .rdata_rj (al_rdata)
  );

  // NOTE: rst_n is sampled only at the rising clock edge. It is a
  // synchronous reset, so it is not listed in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    start_req   = 1'b0;
    resp_done   = 1'b0;
    abort       = 1'b0;
    timeout_hit = (cnt == TO_LAST);
    case (state)
      IDLE: begin
        if (start && req_en && !trap_in) begin
          state_n   = REQ;
          start_req = 1'b1;
        end
      end
      REQ: begin
        if (timeout_hit) begin
          state_n = IDLE;
          abort   = 1'b1;
        end else if (bus_ready) begin
          state_n = RESP;
        end
      end
      RESP: begin
        // A response in the last allowed cycle beats the timeout.
        if (bus_rvalid) begin
          state_n   = IDLE;
          resp_done = 1'b1;
        end else if (timeout_hit) begin
          state_n = IDLE;
          abort   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus_valid = (state == REQ);
  assign busy      = (state != IDLE);

  // NOTE: all sequential state is assigned with non-blocking (<=), so every
  // register sees the values from before the edge regardless of statement
  // order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      bus_addr  <= '0;
      bus_we    <= 1'b0;
      bus_wstrb <= '0;
      bus_wdata <= '0;
      size_q    <= SZ_B;
      off_q     <= 2'b00;
      mrdin     <= '0;
      done      <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      done <= 1'b0;

      if (start_req)             cnt <= '0;
      else if (state != IDLE)    cnt <= cnt + 1'b1;

      if (start_req) begin
        bus_addr  <= {addr[31:2], 2'b00};
        bus_we    <= wr;
        bus_wstrb <= wr ? al_wstrb : 4'b0000;
        bus_wdata <= al_wdata;
        size_q    <= size_in;
        off_q     <= off_in;
      end

      if (resp_done) begin
        done    <= 1'b1;
        bus_err <= 1'b0;
        if (!bus_we) mrdin <= al_rdata;
      end else if (abort) begin
        done    <= 1'b1;
        bus_err <= 1'b1;
        mrdin   <= '0;
      end

`ifdef DMI_MISALIGN_TRAP_EN
      if ((state == IDLE) && start && req_en && trap_in) begin
        done    <= 1'b1;
        bus_err <= 1'b0;
      end
`endif
    end
  end

`ifdef DMI_MISALIGN_TRAP_EN
  // Updated only on a done pulse and held in between.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
    end else if ((state == IDLE) && start && req_en && trap_in) begin
      misalign_err <= 1'b1;
    end else if (resp_done || abort) begin
      misalign_err <= 1'b0;
    end
  end
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_interface.sv
// Self-checking bench for data_mem_interface. Expected values come from a
// behavioural model of the lane rules written as plain arithmetic. A second
// instance with TIMEOUT=4 is used for the abort cases.
module tb_data_mem_interface;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, start_t, wr, b_e, h_e, w_e, bus_ready, bus_rvalid;
  logic [31:0] addr, w_in, bus_rdata;
  logic [15:0] h_in;
  logic [7:0]  b_in;

  logic        bus_valid, bus_we, busy, done, misalign_err, bus_err;
  logic [31:0] bus_addr, bus_wdata, mrdin;
  logic [3:0]  bus_wstrb;

  logic        bus_valid_t, bus_we_t, busy_t, done_t, misalign_err_t, bus_err_t;
  logic [31:0] bus_addr_t, bus_wdata_t, mrdin_t;
  logic [3:0]  bus_wstrb_t;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_mrdin;
  logic [31:0] exp_mrdin_t;

  data_mem_interface dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .wr(wr),
    .b_e(b_e), .h_e(h_e), .w_e(w_e), .w_in(w_in), .h_in(h_in), .b_in(b_in),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
    .bus_we(bus_we), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .mrdin(mrdin),
    .busy(busy), .done(done), .misalign_err(misalign_err), .bus_err(bus_err)
  );

  data_mem_interface #(.TIMEOUT(4)) dut_to (
    .clk(clk), .rst_n(rst_n), .start(start_t), .addr(addr), .wr(wr),
    .b_e(b_e), .h_e(h_e), .w_e(w_e), .w_in(w_in), .h_in(h_in), .b_in(b_in),
    .bus_valid(bus_valid_t), .bus_ready(bus_ready), .bus_addr(bus_addr_t),
    .bus_we(bus_we_t), .bus_wstrb(bus_wstrb_t), .bus_wdata(bus_wdata_t),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .mrdin(mrdin_t),
    .busy(busy_t), .done(done_t), .misalign_err(misalign_err_t), .bus_err(bus_err_t)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int size_of(input logic be, input logic he, input logic we_);
    if (we_) return 4;
    if (he)  return 2;
    if (be)  return 1;
    return 0;
  endfunction

  function automatic logic is_misaligned(input logic [31:0] a, input int sz);
    return (sz == 2 && (a % 2) != 0) || (sz == 4 && (a % 4) != 0);
  endfunction

  function automatic logic [3:0] exp_strb(input logic [31:0] a, input int sz);
    if (sz == 1) return 4'(1 << (a % 4));
    if (sz == 2) return ((a % 4) >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input int sz, input logic [31:0] wd,
                                            input logic [15:0] hd, input logic [7:0] bd);
    if (sz == 1) return 32'(bd) * 32'h0101_0101;
    if (sz == 2) return 32'(hd) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input int sz,
                                           input logic [31:0] rd);
    if (sz == 1) return (rd >> (8 * (a % 4))) & 32'hFF;
    if (sz == 2) return ((a % 4) >= 2) ? (rd >> 16) : (rd & 32'hFFFF);
    return rd;
  endfunction

  // ---------------- one transaction on the main DUT ----------------
  task automatic txn(input string tag, input logic [31:0] a, input logic w,
                     input logic be, input logic he, input logic we_,
                     input logic [31:0] wd, input logic [15:0] hd, input logic [7:0] bd,
                     input logic [31:0] rd, input int rdy_dly, input int rv_dly);
    int   sz;
    logic trap;
    sz   = size_of(be, he, we_);
    trap = 1'b0;
`ifdef DMI_MISALIGN_TRAP_EN
    trap = is_misaligned(a, sz);
`endif
    @(negedge clk);
    addr = a; wr = w; b_e = be; h_e = he; w_e = we_;
    w_in = wd; h_in = hd; b_in = bd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (sz == 0) begin
      check({tag, ".noen_busy"}, busy, 0);
      @(negedge clk);
      check({tag, ".noen_done"}, done, 0);
      return;
    end
    if (trap) begin
      check({tag, ".trap_busy"},  busy, 0);
      check({tag, ".trap_valid"}, bus_valid, 0);
      check({tag, ".trap_done"},  done, 1);
      check({tag, ".trap_mis"},   misalign_err, 1);
      check({tag, ".trap_berr"},  bus_err, 0);
      check({tag, ".trap_mrdin"}, mrdin, exp_mrdin);
      @(negedge clk);
      check({tag, ".trap_pulse"}, done, 0);
      return;
    end
    check({tag, ".busy"},  busy, 1);
    check({tag, ".valid"}, bus_valid, 1);
    check({tag, ".addr"},  bus_addr, a & 32'hFFFF_FFFC);
    check({tag, ".we"},    bus_we, w);
    check({tag, ".wstrb"}, bus_wstrb, w ? exp_strb(a, sz) : 4'h0);
    if (w) check({tag, ".wdata"}, bus_wdata, exp_wdata(sz, wd, hd, bd));
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, bus_valid, 1);
      check({tag, ".hold_busy"},  busy, 1);
      check({tag, ".hold_addr"},  bus_addr, a & 32'hFFFF_FFFC);
      if (w) check({tag, ".hold_wdata"}, bus_wdata, exp_wdata(sz, wd, hd, bd));
      check({tag, ".hold_done"},  done, 0);
    end
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;
    check({tag, ".resp_valid"}, bus_valid, 0);
    check({tag, ".resp_busy"},  busy, 1);
    for (int i = 0; i < rv_dly; i++) begin
      @(negedge clk);
      check({tag, ".wait_busy"}, busy, 1);
      check({tag, ".wait_done"}, done, 0);
    end
    bus_rvalid = 1'b1;
    bus_rdata  = rd;
    @(negedge clk);
    bus_rvalid = 1'b0;
    bus_rdata  = $urandom;
    if (!w) exp_mrdin = exp_load(a, sz, rd);
    check({tag, ".done"},  done, 1);
    check({tag, ".idle"},  busy, 0);
    check({tag, ".berr"},  bus_err, 0);
    check({tag, ".mis"},   misalign_err, 0);
    check({tag, ".mrdin"}, mrdin, exp_mrdin);
    @(negedge clk);
    check({tag, ".pulse"}, done, 0);
  endtask

  // ---------------- abort / race cases on the TIMEOUT=4 instance ----------------
  task automatic to_txn(input string tag, input logic accept, input logic rv_last,
                        input logic [31:0] rd);
    @(negedge clk);
    addr = 32'h0000_6000; wr = 1'b0; b_e = 1'b0; h_e = 1'b0; w_e = 1'b1;
    start_t = 1'b1;
    @(negedge clk);            // cycle 1
    start_t   = 1'b0;
    bus_ready = accept;
    check({tag, ".c1_busy"}, busy_t, 1);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      bus_ready = 1'b0;
      check({tag, ".wait_busy"}, busy_t, 1);
      check({tag, ".wait_done"}, done_t, 0);
      if (c == 4 && rv_last) begin
        bus_rvalid = 1'b1;
        bus_rdata  = rd;
      end
    end
    @(negedge clk);            // cycle 5
    bus_rvalid = 1'b0;
    if (rv_last) begin
      exp_mrdin_t = rd;
      check({tag, ".race_done"},  done_t, 1);
      check({tag, ".race_berr"},  bus_err_t, 0);
      check({tag, ".race_mrdin"}, mrdin_t, exp_mrdin_t);
    end else begin
      exp_mrdin_t = 32'h0;
      check({tag, ".to_done"},  done_t, 1);
      check({tag, ".to_berr"},  bus_err_t, 1);
      check({tag, ".to_mrdin"}, mrdin_t, exp_mrdin_t);
      check({tag, ".to_busy"},  busy_t, 0);
      bus_rvalid = 1'b1;       // late response, must be ignored
      bus_rdata  = 32'hFFFF_FFFF;
      @(negedge clk);
      bus_rvalid = 1'b0;
      check({tag, ".late_done"},  done_t, 0);
      check({tag, ".late_busy"},  busy_t, 0);
      check({tag, ".late_berr"},  bus_err_t, 1);
      check({tag, ".late_mrdin"}, mrdin_t, exp_mrdin_t);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".valid"}, bus_valid, 0);
    check({tag, ".busy"},  busy, 0);
    check({tag, ".done"},  done, 0);
    check({tag, ".we"},    bus_we, 0);
    check({tag, ".wstrb"}, bus_wstrb, 0);
    check({tag, ".addr"},  bus_addr, 0);
    check({tag, ".wdata"}, bus_wdata, 0);
    check({tag, ".mrdin"}, mrdin, 0);
    check({tag, ".mis"},   misalign_err, 0);
    check({tag, ".berr"},  bus_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; start_t = 1'b0; wr = 1'b0;
    b_e = 1'b0; h_e = 1'b0; w_e = 1'b0; addr = '0; w_in = '0; h_in = '0; b_in = '0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    exp_mrdin = '0; exp_mrdin_t = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Directed cases
    txn("byte_load", 32'h0000_1003, 1'b0, 1'b1, 1'b0, 1'b0,
        32'h0, 16'h0, 8'h0, 32'hAABB_CCDD, 0, 0);
    check("byte_load.value", mrdin, 32'h0000_00AA);
    txn("half_store", 32'h0000_2002, 1'b1, 1'b0, 1'b1, 1'b0,
        32'h0, 16'h1234, 8'h0, 32'h0, 0, 0);
    txn("backpressure", 32'h0000_2404, 1'b0, 1'b0, 1'b0, 1'b1,
        32'h0, 16'h0, 8'h0, 32'h1357_9BDF, 5, 1);
    txn("misalign_word", 32'h0000_3001, 1'b0, 1'b0, 1'b0, 1'b1,
        32'h0, 16'h0, 8'h0, 32'h0BAD_F00D, 0, 0);
    txn("no_enable", 32'h0000_3100, 1'b0, 1'b0, 1'b0, 1'b0,
        32'h0, 16'h0, 8'h0, 32'h0, 0, 0);

    // Timeout and response/timeout race on the TIMEOUT=4 instance
    @(negedge clk);
    addr = 32'h0000_5000; wr = 1'b0; b_e = 1'b0; h_e = 1'b0; w_e = 1'b1;
    start_t = 1'b1;
    @(negedge clk);
    start_t = 1'b0; bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus_rvalid = 1'b0;
    exp_mrdin_t = 32'hDEAD_BEEF;
    check("to_pre.done",  done_t, 1);
    check("to_pre.mrdin", mrdin_t, exp_mrdin_t);
    to_txn("timeout_resp", 1'b1, 1'b0, 32'h0);
    to_txn("timeout_req",  1'b0, 1'b0, 32'h0);
    to_txn("race",         1'b1, 1'b1, 32'hC0FF_EE11);

    // Reset while in RESP
    @(negedge clk);
    addr = 32'h0000_4000; wr = 1'b0; b_e = 1'b0; h_e = 1'b0; w_e = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;
    check("rst_mid.in_resp", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_mrdin = '0;
    check_reset_outputs("rst_mid");
    bus_rvalid = 1'b1; bus_rdata = 32'h1111_2222;
    @(negedge clk);
    bus_rvalid = 1'b0;
    check("rst_mid.no_done", done, 0);
    check("rst_mid.idle",    busy, 0);
    txn("after_reset", 32'h0000_4002, 1'b0, 1'b0, 1'b1, 1'b0,
        32'h0, 16'h0, 8'h0, 32'h8765_4321, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      logic [2:0] en;
      en = 3'($urandom_range(0, 7));
      txn("rand", $urandom, 1'($urandom_range(0, 1)), en[0], en[1], en[2],
          $urandom, 16'($urandom), 8'($urandom), $urandom,
          $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
